// File: rtl/mp_latency_mem.sv
// Fixed-latency byte-addressed memory model with single-word/byte access and
// critical-word-first line bursts; one request in flight at a time.
module mp_latency_mem #(
    parameter int unsigned LATENCY       = 16,
    parameter int unsigned MEMORY_SIZE   = 2048,
    parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
    parameter int unsigned LINE_WORDS    = 4
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        bw,
    input  logic        burst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        accept,
    output logic        busy,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        last,
    output logic        wdone,
    output logic        err
);

    localparam int unsigned AW      = $clog2(MEMORY_SIZE);
    localparam int unsigned LW_BITS = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned CW      = 8;

    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

    logic [7:0] mem [MEMORY_SIZE];

    state_t              state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [LW_BITS-1:0]  beat, beat_d;
    logic [31:0]         off_q, wdata_q;
    logic                we_q, bw_q, burst_q;

    logic                busy_d, rvalid_d, last_d, wdone_d, err_d;
    logic [31:0]         rdata_d;

    logic [31:0]         off_in;
    logic                valid_in;
    logic                commit_c;

    logic [31:0]         off_n;
    logic                we_n, bw_n, burst_n;
    logic [LW_BITS-1:0]  last_beat_n;

    logic                emit;
    logic [LW_BITS-1:0]  emit_beat;
    logic [31:0]         sel, line_base, word_addr;

    assign accept = rst_n && req && (state == IDLE);

    // Request decode on the incoming bus
    always_comb begin
        off_in = address - START_ADDRESS;
        if (bw) begin
            valid_in = (off_in <= 32'(MEMORY_SIZE - 4)) && (off_in[1:0] == 2'b00);
        end else begin
            valid_in = (off_in <= 32'(MEMORY_SIZE - 1)) && !(burst && !we);
        end
    end

    // In IDLE the live bus describes the request being accepted; afterwards the latched copy does
    always_comb begin
        off_n   = (state == IDLE) ? off_in : off_q;
        we_n    = (state == IDLE) ? we     : we_q;
        bw_n    = (state == IDLE) ? bw     : bw_q;
        burst_n = ((state == IDLE) ? burst : burst_q) && !we_n && (LINE_WORDS > 1);
        last_beat_n = burst_n ? LW_BITS'(LINE_WORDS - 1) : '0;
    end

    // Next state and next registered outputs
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        beat_d    = beat;
        err_d     = 1'b0;
        emit      = 1'b0;
        emit_beat = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (!valid_in) begin
                        err_d = 1'b1;
                    end else if (LATENCY == 1) begin
                        state_d = XFER;
                        beat_d  = '0;
                        emit    = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_d = XFER;
                    beat_d  = '0;
                    emit    = 1'b1;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            XFER: begin
                if (we_q || (beat == last_beat_n)) begin
                    state_d = IDLE;
                end else begin
                    beat_d    = beat + LW_BITS'(1);
                    emit      = 1'b1;
                    emit_beat = beat + LW_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Critical word first, wrapping inside the aligned line
        sel       = ((off_n >> 2) + 32'(emit_beat)) & 32'(LINE_WORDS - 1);
        line_base = off_n & ~32'(4 * LINE_WORDS - 1);
        word_addr = burst_n ? (line_base + (sel << 2)) : off_n;

        busy_d   = (state_d != IDLE);
        wdone_d  = emit && we_n;
        rvalid_d = emit && !we_n;
        last_d   = rvalid_d && (emit_beat == last_beat_n);
        rdata_d  = '0;
        if (rvalid_d) begin
            if (bw_n) begin
                rdata_d = {mem[AW'(word_addr + 32'd3)], mem[AW'(word_addr + 32'd2)],
                           mem[AW'(word_addr + 32'd1)], mem[AW'(word_addr)]};
            end else begin
                rdata_d = {24'h0, mem[AW'(word_addr)]};
            end
        end
    end

    // State, request latch and registered outputs
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            beat    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            bw_q    <= 1'b0;
            burst_q <= 1'b0;
            busy    <= 1'b0;
            rvalid  <= 1'b0;
            last    <= 1'b0;
            wdone   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            beat   <= beat_d;
            busy   <= busy_d;
            rvalid <= rvalid_d;
            last   <= last_d;
            wdone  <= wdone_d;
            err    <= err_d;
            rdata  <= rdata_d;
            if (accept) begin
                off_q   <= off_in;
                wdata_q <= wdata;
                we_q    <= we;
                bw_q    <= bw;
                burst_q <= burst;
            end
        end
    end

    // Write commits at the end of its completion cycle; reset before then leaves storage untouched
    assign commit_c = (state == XFER) && we_q;

    always_ff @(posedge ck) begin
        if (commit_c) begin
            mem[AW'(off_q)] <= wdata_q[7:0];
            if (bw_q) begin
                mem[AW'(off_q + 32'd1)] <= wdata_q[15:8];
                mem[AW'(off_q + 32'd2)] <= wdata_q[23:16];
                mem[AW'(off_q + 32'd3)] <= wdata_q[31:24];
            end
        end
    end

endmodule
